// File: rtl/dbus_sram_bridge.sv
// Data-side bridge from the MMU's single-cycle physical request to a two-phase
// SRAM-like bus (address handshake, then data handshake), stalling MEM until done.
module dbus_sram_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dbus_en,
  input  logic [3:0]  dbus_wen,
  input  logic [31:0] dbus_paddr,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_streq,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      state_reg, state_next;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;

  logic        capture;
  logic        latch_rdata;
  logic        enc_wr;
  logic [1:0]  enc_size;
  logic [1:0]  enc_lo;

  // The low address bits come from the byte-enable pattern, not from the MMU.
  logic unused_paddr_lo;
  assign unused_paddr_lo = &{1'b0, dbus_paddr[1:0]};

  always_comb begin
    enc_wr   = |dbus_wen;
    enc_size = 2'd2;
    enc_lo   = 2'b00;
    case (dbus_wen)
      4'b0001: begin enc_size = 2'd0; enc_lo = 2'b00; end
      4'b0010: begin enc_size = 2'd0; enc_lo = 2'b01; end
      4'b0100: begin enc_size = 2'd0; enc_lo = 2'b10; end
      4'b1000: begin enc_size = 2'd0; enc_lo = 2'b11; end
      4'b0011: begin enc_size = 2'd1; enc_lo = 2'b00; end
      4'b1100: begin enc_size = 2'd1; enc_lo = 2'b10; end
      // Reads, full words and irregular masks all go out as aligned words.
      default: begin enc_size = 2'd2; enc_lo = 2'b00; end
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    capture     = 1'b0;
    latch_rdata = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (dbus_en && !flush) begin
          capture    = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        if (data_addr_ok) begin
          if (flush) begin
            // Accepted but cancelled: its data phase must still be absorbed.
            state_next = data_data_ok ? S_IDLE : S_DRAIN;
          end else if (data_data_ok) begin
            state_next  = S_DONE;
            latch_rdata = !wr_reg;
          end else begin
            state_next = S_WAIT;
          end
        end else if (flush) begin
          state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_next = data_data_ok ? S_IDLE : S_DRAIN;
        end else if (data_data_ok) begin
          state_next  = S_DONE;
          latch_rdata = !wr_reg;
        end
      end
      S_DONE: begin
        if (!pipe_stall || flush) begin
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (data_data_ok) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= S_IDLE;
      wr_reg    <= 1'b0;
      size_reg  <= 2'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (capture) begin
        wr_reg    <= enc_wr;
        size_reg  <= enc_size;
        addr_reg  <= {dbus_paddr[31:2], enc_lo};
        wdata_reg <= dbus_wdata;
      end
      if (latch_rdata) begin
        rdata_reg <= data_rdata;
      end
    end
  end

  assign data_req   = (state_reg == S_REQ);
  assign data_wr    = wr_reg;
  assign data_size  = size_reg;
  assign data_addr  = addr_reg;
  assign data_wdata = wdata_reg;
  assign dbus_rdata = rdata_reg;
  // DONE releases the pipeline; the held dbus_en is not reissued from there.
  assign dbus_streq = dbus_en && !flush && (state_reg != S_DONE);

endmodule

// File: tb/tb_dbus_sram_bridge.sv
// Scoreboard bench for dbus_sram_bridge: directed accesses push expected bus
// requests and completions; a negedge monitor pops and compares them.
module tb_dbus_sram_bridge;

  logic        clk;
  logic        resetn;
  logic        dbus_en;
  logic [3:0]  dbus_wen;
  logic [31:0] dbus_paddr;
  logic [31:0] dbus_wdata;
  logic [31:0] dbus_rdata;
  logic        dbus_streq;
  logic        pipe_stall;
  logic        flush;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  dbus_sram_bridge dut (
    .clk          (clk),
    .resetn       (resetn),
    .dbus_en      (dbus_en),
    .dbus_wen     (dbus_wen),
    .dbus_paddr   (dbus_paddr),
    .dbus_wdata   (dbus_wdata),
    .dbus_rdata   (dbus_rdata),
    .dbus_streq   (dbus_streq),
    .pipe_stall   (pipe_stall),
    .flush        (flush),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    int          stall;
  } cmp_t;

  localparam logic [31:0] JUNK = 32'hBADBAD00;

  req_t req_q[$];
  cmp_t cmp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input int cycles);
    req_t r;
    r.wr = wr; r.size = size; r.addr = addr; r.wdata = wdata; r.cycles = cycles;
    req_q.push_back(r);
  endtask

  task automatic expect_done(input logic [31:0] rdata, input int stall);
    cmp_t c;
    c.rdata = rdata; c.stall = stall;
    cmp_q.push_back(c);
  endtask

  // One access: addr_ok in REQ cycle a, data_ok b cycles later, then hold DONE.
  task automatic access(input logic [3:0] wen, input logic [31:0] paddr, input logic [31:0] wdata,
                        input int a, input int b, input logic [31:0] rd, input int hold,
                        input logic ewr, input logic [1:0] esize, input logic [31:0] eaddr,
                        input logic [31:0] erdata);
    expect_req(ewr, esize, eaddr, wdata, a);
    expect_done(erdata, 1 + a + b);
    dbus_en = 1'b1; dbus_wen = wen; dbus_paddr = paddr; dbus_wdata = wdata;
    step();
    for (int i = 1; i <= a; i++) begin
      data_addr_ok = (i == a);
      data_data_ok = (i == a) ? (b == 0) : (i == 1);
      data_rdata   = (i == a && b == 0) ? rd : JUNK;
      step();
    end
    data_addr_ok = 1'b0;
    for (int j = 1; j <= b; j++) begin
      data_data_ok = (j == b);
      data_rdata   = (j == b) ? rd : JUNK;
      step();
    end
    for (int k = 0; k < hold; k++) begin
      pipe_stall = 1'b1;
      data_data_ok = (k == 0);
      data_rdata = JUNK;
      step();
    end
    data_data_ok = 1'b0; pipe_stall = 1'b0;
    step();
    dbus_en = 1'b0; dbus_wen = 4'b0000;
  endtask

  // Monitor: sampled on negedge, inputs only change just after posedge.
  logic        prev_req, prev_addr_ok, prev_done, done_now;
  int          req_cnt, stall_cnt;
  logic [31:0] cur_rdata = 32'd0;

  always @(negedge clk) begin
    req_t re;
    cmp_t ce;
    if (!resetn) begin
      prev_req = 1'b0; prev_addr_ok = 1'b0; prev_done = 1'b0;
      req_cnt = 0; stall_cnt = 0; cur_rdata = 32'd0;
    end else begin
      done_now = dbus_en && !flush && !dbus_streq;
      if (data_req) begin
        if (!prev_req) req_cnt = 0;
        req_cnt++;
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'(data_req), 32'd0);
        end else begin
          chk("req_wr", 32'(data_wr), 32'(req_q[0].wr));
          chk("req_size", 32'(data_size), 32'(req_q[0].size));
          chk("req_addr", data_addr, req_q[0].addr);
          chk("req_wdata", data_wdata, req_q[0].wdata);
          if (data_addr_ok) begin
            re = req_q.pop_front();
            chk("req_cycles", 32'(req_cnt), 32'(re.cycles));
            $display("req  accepted addr=%h wr=%0d size=%0d wdata=%h cycles=%0d",
                     data_addr, data_wr, data_size, data_wdata, req_cnt);
          end
        end
      end else if (prev_req && !prev_addr_ok && req_q.size() != 0) begin
        re = req_q.pop_front();
        chk("req_cancel_cycles", 32'(req_cnt), 32'(re.cycles));
        $display("req  withdrawn addr=%h cycles=%0d", re.addr, req_cnt);
      end

      if (done_now && !prev_done) begin
        if (cmp_q.size() == 0) begin
          chk("unexpected_done", 32'(done_now), 32'd0);
        end else begin
          ce = cmp_q.pop_front();
          cur_rdata = ce.rdata;
          chk("done_rdata", dbus_rdata, ce.rdata);
          chk("stall_cycles", 32'(stall_cnt), 32'(ce.stall));
          $display("done rdata=%h stall=%0d", dbus_rdata, stall_cnt);
        end
        stall_cnt = 0;
      end else if (done_now) begin
        chk("rdata_hold", dbus_rdata, cur_rdata);
      end else if (dbus_en && !flush && dbus_streq) begin
        stall_cnt++;
      end else begin
        stall_cnt = 0;
      end
      prev_done = done_now; prev_req = data_req; prev_addr_ok = data_addr_ok;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; dbus_en = 1'b0; dbus_wen = 4'b0000; dbus_paddr = 32'd0; dbus_wdata = 32'd0;
    pipe_stall = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    step(); step();
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_wr", 32'(data_wr), 32'd0);
    chk("rst_size", 32'(data_size), 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    chk("rst_rdata", dbus_rdata, 32'd0);
    chk("rst_streq", 32'(dbus_streq), 32'd0);
    resetn = 1'b1;
    step();

    //      wen      paddr         wdata         a  b  rd            hold wr  size   addr          rdata
    access(4'b0000, 32'h0000_1004, 32'h0000_0000, 1, 0, 32'hDEAD_BEEF, 0, 1'b0, 2'd2, 32'h0000_1004, 32'hDEAD_BEEF);
    access(4'b0100, 32'h2000_0000, 32'h1122_3344, 1, 0, JUNK,          0, 1'b1, 2'd0, 32'h2000_0002, 32'hDEAD_BEEF);
    access(4'b1100, 32'h2000_0000, 32'hAABB_CCDD, 1, 0, JUNK,          0, 1'b1, 2'd1, 32'h2000_0002, 32'hDEAD_BEEF);
    access(4'b0000, 32'h0000_3008, 32'h0000_0000, 3, 4, 32'h1234_5678, 0, 1'b0, 2'd2, 32'h0000_3008, 32'h1234_5678);
    access(4'b0000, 32'h4000_000C, 32'h0000_0000, 1, 2, 32'hCAFE_F00D, 3, 1'b0, 2'd2, 32'h4000_000C, 32'hCAFE_F00D);
    access(4'b0010, 32'h5000_0003, 32'h0000_5A00, 2, 1, JUNK,          0, 1'b1, 2'd0, 32'h5000_0001, 32'hCAFE_F00D);
    access(4'b0101, 32'h6000_0006, 32'h0102_0304, 1, 1, JUNK,          0, 1'b1, 2'd2, 32'h6000_0004, 32'hCAFE_F00D);

    // Flush while still in REQ: request withdrawn after 2 cycles, no completion.
    expect_req(1'b1, 2'd0, 32'h0000_0B00, 32'h0000_00EE, 2);
    dbus_en = 1'b1; dbus_wen = 4'b0001; dbus_paddr = 32'h0000_0B00; dbus_wdata = 32'h0000_00EE;
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0; dbus_en = 1'b0; dbus_wen = 4'b0000;
    step();

    // Flush in WAIT, new access raised during DRAIN, cancelled data discarded.
    expect_req(1'b0, 2'd2, 32'h0000_9000, 32'h0000_0000, 1);
    dbus_en = 1'b1; dbus_wen = 4'b0000; dbus_paddr = 32'h0000_9000; dbus_wdata = 32'h0000_0000;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    expect_req(1'b1, 2'd2, 32'h0000_A000, 32'h0BAD_F00D, 1);
    expect_done(32'hCAFE_F00D, 4);
    dbus_wen = 4'b1111; dbus_paddr = 32'h0000_A000; dbus_wdata = 32'h0BAD_F00D;
    step();
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    step();
    data_data_ok = 1'b0;
    step();
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = JUNK;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    step();
    dbus_en = 1'b0; dbus_wen = 4'b0000;
    step();

    // Asynchronous reset while a write waits for its data phase.
    expect_req(1'b1, 2'd2, 32'h8000_0000, 32'h55AA_55AA, 1);
    dbus_en = 1'b1; dbus_wen = 4'b1111; dbus_paddr = 32'h8000_0000; dbus_wdata = 32'h55AA_55AA;
    step();
    data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("arst_req", 32'(data_req), 32'd0);
    chk("arst_wr", 32'(data_wr), 32'd0);
    chk("arst_size", 32'(data_size), 32'd0);
    chk("arst_addr", data_addr, 32'd0);
    chk("arst_wdata", data_wdata, 32'd0);
    chk("arst_rdata", dbus_rdata, 32'd0);
    chk("arst_streq_idle", 32'(dbus_streq), 32'd1);
    dbus_en = 1'b0; dbus_wen = 4'b0000;
    step();
    step();
    resetn = 1'b1;
    step();

    access(4'b1000, 32'h7000_0000, 32'h9900_0000, 2, 1, JUNK,          0, 1'b1, 2'd0, 32'h7000_0003, 32'h0000_0000);
    access(4'b0000, 32'h0000_0010, 32'h0000_0000, 1, 3, 32'h0F0F_0F0F, 0, 1'b0, 2'd2, 32'h0000_0010, 32'h0F0F_0F0F);

    step(); step();
    chk("req_queue_empty", 32'(req_q.size()), 32'd0);
    chk("done_queue_empty", 32'(cmp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
